// File: rtl/dvp_tx_pkg.sv
// dvp_tx_pkg: DVP transmitter states, byte-order constant, line-period and byte-select helpers
package dvp_tx_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_VSYNC, ST_V_BP, ST_ACTIVE, ST_H_BLANK, ST_V_FP} state_t;
  localparam bit HI_FIRST = 1'b1;
  function automatic int line_period(int h_active, int h_blank);
    return 2 * h_active + h_blank;
  endfunction
  function automatic logic [7:0] pix_byte(logic [15:0] p, logic second);
    return (second ^ !HI_FIRST) ? p[7:0] : p[15:8];
  endfunction
endpackage

// File: rtl/dvp_timing_gen.sv
// dvp_timing_gen: slot/line/frame timing FSM; ports clk, rst_n, en -> pclk phase, adv (slot boundary next edge), fetch, next state/parity, frame_done
module dvp_timing_gen
  import dvp_tx_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 144,
  parameter int VS_LINES = 3,
  parameter int V_BP     = 17,
  parameter int V_FP     = 10
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  output logic   pclk,
  output logic   adv,
  output logic   fetch,
  output logic   nxt_odd,
  output logic   frame_done,
  output state_t state,
  output state_t nxt_state
);
  localparam int LP   = line_period(H_ACTIVE, H_BLANK);
  localparam int M1   = V_ACTIVE > VS_LINES ? V_ACTIVE : VS_LINES;
  localparam int M2   = V_BP > V_FP ? V_BP : V_FP;
  localparam int LMAX = M1 > M2 ? M1 : M2;
  localparam int SW   = $clog2(LP + 1);
  localparam int LW   = $clog2(LMAX + 1);
  if (H_ACTIVE < 1 || V_ACTIVE < 1) begin : g_bad_params
    $error("dvp_timing_gen: H_ACTIVE and V_ACTIVE must be >= 1");
  end
  logic phase, slot_end, seg_end, last_line, multi;
  logic [SW-1:0] slot_cnt, nxt_slot;
  logic [LW-1:0] line_cnt, nxt_line;
  int seg_slots, seg_lines;
  state_t start_st, fp_st;
  always_comb begin
    multi     = state inside {ST_VSYNC, ST_V_BP, ST_V_FP};
    seg_slots = state == ST_ACTIVE ? 2 * H_ACTIVE : state == ST_H_BLANK ? H_BLANK : state == ST_IDLE ? 1 : LP;
    seg_lines = state == ST_VSYNC ? VS_LINES : state == ST_V_BP ? V_BP : V_FP;
    slot_end  = int'(slot_cnt) == seg_slots - 1;
    seg_end   = slot_end && (!multi || int'(line_cnt) == seg_lines - 1);
    last_line = int'(line_cnt) == V_ACTIVE - 1;
    start_st  = VS_LINES > 0 ? ST_VSYNC : V_BP > 0 ? ST_V_BP : ST_ACTIVE;
    fp_st     = V_FP > 0 ? ST_V_FP : en ? start_st : ST_IDLE;
    nxt_state = state;
    if (seg_end)
      case (state)
        ST_IDLE, ST_V_FP: nxt_state = en ? start_st : ST_IDLE;
        ST_VSYNC:         nxt_state = V_BP > 0 ? ST_V_BP : ST_ACTIVE;
        ST_V_BP:          nxt_state = ST_ACTIVE;
        ST_ACTIVE:        nxt_state = H_BLANK > 0 ? ST_H_BLANK : last_line ? fp_st : ST_ACTIVE;
        default:          nxt_state = last_line ? fp_st : ST_ACTIVE;
      endcase
    nxt_slot = seg_end || slot_end ? '0 : slot_cnt + 1'b1;
    nxt_line = !seg_end ? (slot_end ? line_cnt + 1'b1 : line_cnt)
             : nxt_state == ST_ACTIVE && state inside {ST_ACTIVE, ST_H_BLANK} ? line_cnt + 1'b1
             : nxt_state == ST_H_BLANK ? line_cnt : '0;
    adv        = phase;
    pclk       = phase;
    nxt_odd    = nxt_slot[0];
    fetch      = phase && nxt_state == ST_ACTIVE && !nxt_slot[0];
    frame_done = phase && seg_end && (state == ST_V_FP ||
                 (V_FP == 0 && last_line && (state == ST_H_BLANK || (state == ST_ACTIVE && H_BLANK == 0))));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      phase    <= 1'b0;
      state    <= ST_IDLE;
      slot_cnt <= '0;
      line_cnt <= '0;
    end else begin
      phase <= !phase;
      if (phase) begin
        state    <= nxt_state;
        slot_cnt <= nxt_slot;
        line_cnt <= nxt_line;
      end
    end
endmodule

// File: rtl/dvp_pixel_tx.sv
// dvp_pixel_tx: DVP sensor emulator; RGB565 stream (iPIX_*) in, oPCLK/oVSYNC/oHREF/oDATA byte stream out, oFRAME_DONE pulse, oUNDERRUN flag
module dvp_pixel_tx
  import dvp_tx_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 144,
  parameter int VS_LINES = 3,
  parameter int V_BP     = 17,
  parameter int V_FP     = 10
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iEN,
  input  logic [15:0] iPIX_DATA,
  input  logic        iPIX_VALID,
  output logic        oPIX_READY,
  output logic        oPCLK,
  output logic        oVSYNC,
  output logic        oHREF,
  output logic [7:0]  oDATA,
  output logic        oFRAME_DONE,
  output logic        oUNDERRUN
);
  state_t state, nxt_state;
  logic adv, fetch, nxt_odd;
  logic [15:0] hold, px;
  dvp_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_BLANK(H_BLANK),
    .VS_LINES(VS_LINES), .V_BP(V_BP), .V_FP(V_FP)
  ) u_timing (
    .clk(iCLK), .rst_n(iRST_N), .en(iEN), .pclk(oPCLK), .adv(adv), .fetch(fetch),
    .nxt_odd(nxt_odd), .frame_done(oFRAME_DONE), .state(state), .nxt_state(nxt_state)
  );
  assign oPIX_READY = fetch;
  assign px = iPIX_VALID ? iPIX_DATA : '0;
  always_ff @(posedge iCLK or negedge iRST_N)
    if (!iRST_N) begin
      oVSYNC    <= 1'b0;
      oHREF     <= 1'b0;
      oDATA     <= '0;
      oUNDERRUN <= 1'b0;
      hold      <= '0;
    end else if (adv) begin
      oVSYNC    <= nxt_state == ST_VSYNC;
      oHREF     <= nxt_state == ST_ACTIVE;
      oDATA     <= nxt_state != ST_ACTIVE ? '0 : pix_byte(nxt_odd ? hold : px, nxt_odd);
      oUNDERRUN <= nxt_state == ST_VSYNC && state != ST_VSYNC ? 1'b0 : oUNDERRUN | (fetch & !iPIX_VALID);
      if (fetch) hold <= px;
    end
endmodule

// File: tb/tb_dvp_pixel_tx.sv
// tb_dvp_pixel_tx: scoreboard bench with frame-timing reference model for dvp_pixel_tx
module tb_dvp_pixel_tx;
  localparam int HA = 4, VA = 2, HB = 3, VS = 1, VBP = 1, VFP = 1;
  localparam int LPS = 2 * HA + HB;
  localparam int FR = 2 * LPS * (VS + VBP + VA + VFP);
  logic iCLK = 1'b0, iRST_N = 1'b0, iEN = 1'b0, iPIX_VALID = 1'b0;
  logic [15:0] iPIX_DATA = '0;
  logic oPIX_READY, oPCLK, oVSYNC, oHREF, oFRAME_DONE, oUNDERRUN;
  logic [7:0] oDATA;
  int n_chk = 0, n_fail = 0, mode = 0;
  logic [7:0] sb[$];
  logic [15:0] nxt_pix = 16'h1234, spx;
  int src_n = 0;
  int t = 0, hs = 0, wait_cnt = 0, slot, line, pos;
  bit in_frame = 0, exp_under = 0, prev_pclk = 0;

  dvp_pixel_tx #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .VS_LINES(VS), .V_BP(VBP), .V_FP(VFP)
  ) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iEN(iEN), .iPIX_DATA(iPIX_DATA), .iPIX_VALID(iPIX_VALID),
    .oPIX_READY(oPIX_READY), .oPCLK(oPCLK), .oVSYNC(oVSYNC), .oHREF(oHREF), .oDATA(oDATA),
    .oFRAME_DONE(oFRAME_DONE), .oUNDERRUN(oUNDERRUN)
  );

  always #5 iCLK = ~iCLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wait_ev(input bit href);
    for (int i = 0; i < 300; i++) begin
      @(negedge iCLK); #3;
      if (href ? oHREF : oFRAME_DONE) return;
    end
    n_chk++;
    n_fail++;
    $display("FAIL timeout waiting for %s", href ? "href" : "frame_done");
  endtask

  // source: offers pixels, and at each handshake pushes the bytes the receiver must see
  always begin
    @(negedge iCLK);
    if (oVSYNC) src_n = 0;
    iPIX_VALID = mode == 0 ? 1'b1 : mode == 1 ? src_n != 2 : $urandom_range(3, 0) != 0;
    iPIX_DATA  = mode == 2 ? 16'($urandom) : nxt_pix;
    #1;
    if (iRST_N && oPIX_READY) begin
      spx = iPIX_VALID ? iPIX_DATA : 16'h0000;
      sb.push_back(spx[15:8]);
      sb.push_back(spx[7:0]);
      if (iPIX_VALID) nxt_pix++;
      src_n++;
    end
  end

  // monitor: frame timing from slot/line arithmetic, bytes from the scoreboard
  always begin
    @(negedge iCLK); #2;
    if (!iRST_N) begin
      in_frame  = 0;
      wait_cnt  = 0;
      exp_under = 0;
      sb.delete();
    end else begin
      if (!in_frame && oVSYNC) begin
        in_frame = 1;
        t = 0;
      end
      if (in_frame) begin
        wait_cnt = 0;
        if (t == 0) begin
          exp_under = 0;
          hs = 0;
        end
        slot = t / 2;
        line = slot / LPS;
        pos  = slot % LPS;
        chk("vsync", 32'(oVSYNC), 32'(line < VS));
        chk("href", 32'(oHREF), 32'(line >= VS + VBP && line < VS + VBP + VA && pos < 2 * HA));
        chk("frame_done", 32'(oFRAME_DONE), 32'(t == FR - 1));
        chk("pclk_phase", 32'(oPCLK), t % 2);
      end else begin
        chk("idle_syncs", 32'({oVSYNC, oHREF, oFRAME_DONE}), 0);
        chk("idle_pclk", 32'(oPCLK), 32'(!prev_pclk));
        wait_cnt = iEN ? wait_cnt + 1 : 0;
        if (wait_cnt == 6) chk("vsync_start", 32'(oVSYNC), 1);
      end
      if (oHREF && oPCLK) begin
        chk("sb_level", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) chk("data", 32'(oDATA), 32'(sb.pop_front()));
      end
      if (!oHREF) chk("data_blank", 32'(oDATA), 0);
      chk("underrun", 32'(oUNDERRUN), 32'(exp_under));
      if (oPIX_READY) begin
        hs++;
        if (!iPIX_VALID) exp_under = 1;
      end
      if (in_frame) begin
        if (t == FR - 1) begin
          chk("handshakes", hs, HA * VA);
          chk("sb_drain", sb.size(), 0);
        end
        t++;
        if (t == FR) begin
          t = 0;
          in_frame = iEN;
        end
      end
    end
    prev_pclk = oPCLK;
  end

  initial begin
    repeat (3) @(negedge iCLK);
    #3;
    chk("reset_outputs", 32'({oPCLK, oVSYNC, oHREF, oFRAME_DONE, oUNDERRUN, oPIX_READY, oDATA}), 0);
    iEN = 1'b1;
    iRST_N = 1'b1;
    wait_ev(0);
    wait_ev(0);
    mode = 1;
    wait_ev(0);
    mode = 2;
    wait_ev(0);
    wait_ev(0);
    mode = 0;
    wait_ev(1);
    iEN = 1'b0;
    wait_ev(0);
    repeat (30) @(negedge iCLK);
    #3;
    iEN = 1'b1;
    wait_ev(1);
    @(negedge iCLK);
    #3;
    iRST_N = 1'b0;
    #1;
    chk("async_reset", 32'({oPCLK, oVSYNC, oHREF, oFRAME_DONE, oUNDERRUN, oPIX_READY, oDATA}), 0);
    repeat (3) @(negedge iCLK);
    #3;
    iRST_N = 1'b1;
    wait_ev(0);
    wait_ev(0);
    repeat (5) @(negedge iCLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
